// File: rtl/clkdiv_rate_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// clkdiv_pkg
// Shared definitions for the clock-divider rate controller.
//   DIV_W          width of the divider max value
//   rate_state_t   run-control FSM states
//   lvl_width()    width of a level index for a given number of levels
//   level_to_max() rate table: level L selects base >> L
// ----------------------------------------------------------------------------
package clkdiv_pkg;

    localparam int unsigned DIV_W = 26;

    typedef enum logic [1:0] {
        STOP,
        ARM,
        RUN,
        PEND
    } rate_state_t;

    // A single-level table still needs a 1-bit level port.
    function automatic int unsigned lvl_width(input int unsigned levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

    // Logical shift at full divider width; higher level means a shorter period.
    function automatic logic [DIV_W-1:0] level_to_max(input logic [DIV_W-1:0] base,
                                                       input int unsigned     lvl);
        return base >> lvl;
    endfunction

endpackage

// File: rtl/clkdiv_rate_ctrl_if.sv
// ----------------------------------------------------------------------------
// clkdiv_rate_ctrl_if
// Request/response bundle between the rate controller, its user and the
// divider placed beside it.
//   start/stop/faster/slower  1-cycle request pulses
//   tc                        divider terminal-count pulse
//   div_nrst                  divider reset, active-low
//   div_max                   divider max value
//   cnt_en                    qualified 1-cycle tick to the downstream counter
//   level                     active rate level
//   busy                      a rate change is waiting for the next tc
//   rej                       1-cycle pulse: request saturated or ignored
// Modports: master = environment/user side, slave = controller.
// ----------------------------------------------------------------------------
interface clkdiv_rate_ctrl_if #(
    parameter int unsigned LVL_W = 2
) ();
    import clkdiv_pkg::*;

    logic             start;
    logic             stop;
    logic             faster;
    logic             slower;
    logic             tc;
    logic             div_nrst;
    logic [DIV_W-1:0] div_max;
    logic             cnt_en;
    logic [LVL_W-1:0] level;
    logic             busy;
    logic             rej;

    modport master (
        output start, stop, faster, slower, tc,
        input  div_nrst, div_max, cnt_en, level, busy, rej
    );

    modport slave (
        input  start, stop, faster, slower, tc,
        output div_nrst, div_max, cnt_en, level, busy, rej
    );

endinterface

// File: rtl/clkdiv_rate_ctrl.sv
// ----------------------------------------------------------------------------
// clkdiv_rate_ctrl
// Run control and rate scheduler for an external clock divider. Starts and
// stops the divider, picks its period from a LEVELS-entry table and applies
// rate changes only on the divider terminal count so the tick stream never
// glitches. All outputs are registered.
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   clkdiv_rate_ctrl_if.slave (requests and tc in; divider control,
//         cnt_en, level, busy, rej out)
// Optional feature: define RATE_AUTOCYCLE_EN to auto-advance the level every
// CYCLE_TICKS cnt_en pulses in RUN (wrapping from LEVELS-1 to 0).
// ----------------------------------------------------------------------------
module clkdiv_rate_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned BASE_MAX    = 26_999_999,
    parameter int unsigned LEVELS      = 4,
    parameter int unsigned INIT_LEVEL  = 0,
    parameter int unsigned CYCLE_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    clkdiv_rate_ctrl_if.slave bus
);

    localparam int unsigned      LVL_W    = lvl_width(LEVELS);
    localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(LEVELS - 1);
    localparam logic [LVL_W-1:0] LVL_INIT = LVL_W'(INIT_LEVEL);
    localparam logic [DIV_W-1:0] BASE_D   = DIV_W'(BASE_MAX);

    if (((BASE_MAX >> (LEVELS - 1)) < 2) || (INIT_LEVEL >= LEVELS) || (CYCLE_TICKS < 1))
    begin : g_param_check
        $error("clkdiv_rate_ctrl: illegal BASE_MAX/LEVELS/INIT_LEVEL/CYCLE_TICKS");
    end

    rate_state_t      state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] div_max_q, div_max_d;
    logic             div_nrst_q, div_nrst_d;
    logic             cnt_en_q, cnt_en_d;
    logic             busy_q, busy_d;
    logic             rej_q, rej_d;

    logic             req;
    logic             up;
    logic             sat_level;
    logic             sat_pend;
    logic [LVL_W-1:0] pend_nxt;
    logic             auto_fire;

`ifdef RATE_AUTOCYCLE_EN
    localparam int unsigned TICK_W = $clog2(CYCLE_TICKS + 1);

    logic [TICK_W-1:0] tick_q, tick_d;

    // Counts cnt_en pulses seen in RUN; the CYCLE_TICKS-th fires an internal step.
    always_comb begin
        auto_fire = (state_q == RUN) && cnt_en_q && (tick_q == TICK_W'(CYCLE_TICKS - 1));
        tick_d    = tick_q;
        if (bus.stop || bus.faster || bus.slower) begin
            tick_d = '0;
        end else if ((state_q == RUN) && cnt_en_q) begin
            tick_d = auto_fire ? '0 : tick_q + TICK_W'(1);
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    // Opposite requests cancel; saturation is judged against the value being stepped.
    assign req       = bus.faster ^ bus.slower;
    assign up        = bus.faster;
    assign sat_level = up ? (level_q == LVL_TOP) : (level_q == '0);
    assign sat_pend  = up ? (pend_q == LVL_TOP) : (pend_q == '0);

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        pend_d     = pend_q;
        div_max_d  = div_max_q;
        div_nrst_d = div_nrst_q;
        busy_d     = busy_q;
        cnt_en_d   = 1'b0;
        rej_d      = 1'b0;
        pend_nxt   = pend_q;

        if (bus.stop && (state_q != STOP)) begin
            // Any pending level is dropped; level and div_max stay as they are.
            state_d    = STOP;
            div_nrst_d = 1'b0;
            busy_d     = 1'b0;
            pend_d     = level_q;
        end else begin
            case (state_q)
                STOP: begin
                    if (!bus.stop) begin
                        rej_d = req;
                        if (bus.start) begin
                            state_d = ARM;
                        end
                    end
                end
                // Divider held in reset one more cycle so div_max is settled at release.
                ARM: begin
                    state_d    = RUN;
                    div_nrst_d = 1'b1;
                    rej_d      = req | bus.start;
                end
                RUN: begin
                    cnt_en_d = bus.tc;
                    rej_d    = bus.start;
                    if (req) begin
                        if (sat_level) begin
                            rej_d = 1'b1;
                        end else begin
                            pend_d  = up ? level_q + LVL_W'(1) : level_q - LVL_W'(1);
                            state_d = PEND;
                            busy_d  = 1'b1;
                        end
                    end else if (auto_fire) begin
                        pend_d  = (level_q == LVL_TOP) ? '0 : level_q + LVL_W'(1);
                        state_d = PEND;
                        busy_d  = 1'b1;
                    end
                end
                PEND: begin
                    cnt_en_d = bus.tc;
                    rej_d    = bus.start;
                    if (req) begin
                        if (sat_pend) begin
                            rej_d = 1'b1;
                        end else begin
                            pend_nxt = up ? pend_q + LVL_W'(1) : pend_q - LVL_W'(1);
                        end
                    end
                    pend_d = pend_nxt;
                    // Commit on tc: the divider is at count 0 now, so the new max
                    // is in place before it can reach any terminal count.
                    if (bus.tc) begin
                        level_d   = pend_nxt;
                        div_max_d = level_to_max(BASE_D, int'(pend_nxt));
                        state_d   = RUN;
                        busy_d    = 1'b0;
                    end
                end
                default: begin
                    state_d    = STOP;
                    div_nrst_d = 1'b0;
                    busy_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STOP;
            level_q    <= LVL_INIT;
            pend_q     <= LVL_INIT;
            div_max_q  <= level_to_max(BASE_D, INIT_LEVEL);
            div_nrst_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            rej_q      <= 1'b0;
`ifdef RATE_AUTOCYCLE_EN
            tick_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            pend_q     <= pend_d;
            div_max_q  <= div_max_d;
            div_nrst_q <= div_nrst_d;
            cnt_en_q   <= cnt_en_d;
            busy_q     <= busy_d;
            rej_q      <= rej_d;
`ifdef RATE_AUTOCYCLE_EN
            tick_q     <= tick_d;
`endif
        end
    end

    assign bus.div_nrst = div_nrst_q;
    assign bus.div_max  = div_max_q;
    assign bus.cnt_en   = cnt_en_q;
    assign bus.level    = level_q;
    assign bus.busy     = busy_q;
    assign bus.rej      = rej_q;

endmodule
